// File: rtl/int_dispatch_buf_pkg.sv
// Shared types for the integer dispatch path.
// uop_types carries the renamed uop layout.
// int_rs_types carries the dispatch-buffer group type and its sizing constants.
package uop_types;
  localparam int PRF_IDX = 6;

  typedef struct packed {
    logic [7:0]         opcode;
    logic [PRF_IDX-1:0] rd_phy;
    logic [PRF_IDX-1:0] rs1_phy;
    logic               rs1_valid;
    logic [PRF_IDX-1:0] rs2_phy;
    logic               rs2_valid;
  } uop_t;
endpackage

package int_rs_types;
  import uop_types::*;

  localparam int ID_WIDTH   = 2;
  localparam int DISP_DEPTH = 4;
  localparam int DISP_IDX   = $clog2(DISP_DEPTH);
  localparam int CDB_WIDTH  = 2;

  typedef struct packed {
    logic [ID_WIDTH-1:0] valid;
    uop_t [ID_WIDTH-1:0] uop;
  } disp_grp_t;
endpackage

// File: rtl/int_dispatch_buf_wakeup.sv
// Combinational CDB matcher for one uop.
// A broadcast to physical register 0 never wakes anything, because p0 is the
// hard-wired zero register and is never produced.
module disp_wakeup
  import uop_types::*;
#(
  parameter int CDB_WIDTH = 2
) (
  input  uop_t                              uop_in,
  input  logic [CDB_WIDTH-1:0]              cdb_valid,
  input  logic [CDB_WIDTH-1:0][PRF_IDX-1:0] cdb_rd_phy,
  output uop_t                              uop_out
);

  logic hit1_s;
  logic hit2_s;

  // Reduce all broadcast ports into one hit per source operand.
  always_comb begin
    hit1_s = 1'b0;
    hit2_s = 1'b0;
    for (int k = 0; k < CDB_WIDTH; k++) begin
      hit1_s = hit1_s | (cdb_valid[k] && (cdb_rd_phy[k] != {PRF_IDX{1'b0}}) &&
                         (cdb_rd_phy[k] == uop_in.rs1_phy));
      hit2_s = hit2_s | (cdb_valid[k] && (cdb_rd_phy[k] != {PRF_IDX{1'b0}}) &&
                         (cdb_rd_phy[k] == uop_in.rs2_phy));
    end
  end

  // Set the ready bits on a hit; all other fields pass through unchanged.
  always_comb begin
    uop_out           = uop_in;
    uop_out.rs1_valid = uop_in.rs1_valid | hit1_s;
    uop_out.rs2_valid = uop_in.rs2_valid | hit2_s;
  end

endmodule

// File: rtl/int_dispatch_buf.sv
// Dispatch-side group FIFO that feeds the integer reservation station.
// Head and tail pointers carry an extra wrap bit, so full and empty are both
// derived from the pointers alone.
// Buffered uops snoop the CDB every cycle, and the head group also gets a
// same-cycle bypass on its way out to the RS.
module int_dispatch_buf
  import uop_types::*;
#(
  parameter int ID_WIDTH   = int_rs_types::ID_WIDTH,
  parameter int DISP_DEPTH = int_rs_types::DISP_DEPTH,
  parameter int CDB_WIDTH  = int_rs_types::CDB_WIDTH,
  parameter int DISP_IDX   = $clog2(DISP_DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [ID_WIDTH-1:0]               rn_valid,
  input  uop_t [ID_WIDTH-1:0]               rn_uop,
  output logic                              rn_ready,
  output logic [ID_WIDTH-1:0]               rs_valid,
  output uop_t [ID_WIDTH-1:0]               rs_uop,
  input  logic                              rs_ready,
  input  logic [CDB_WIDTH-1:0]              cdb_valid,
  input  logic [CDB_WIDTH-1:0][PRF_IDX-1:0] cdb_rd_phy
);

  logic [DISP_IDX:0]   head_r;
  logic [DISP_IDX:0]   tail_r;
  logic [ID_WIDTH-1:0] valid_mem_r [DISP_DEPTH];
  uop_t [ID_WIDTH-1:0] uop_mem_r   [DISP_DEPTH];
  uop_t [ID_WIDTH-1:0] woken_mem_s [DISP_DEPTH];
  uop_t [ID_WIDTH-1:0] rn_woken_s;

  logic [DISP_IDX-1:0] head_idx_s;
  logic [DISP_IDX-1:0] tail_idx_s;
  logic                empty_s;
  logic                full_s;
  logic                enq_s;
  logic                deq_s;

  assign head_idx_s = head_r[DISP_IDX-1:0];
  assign tail_idx_s = tail_r[DISP_IDX-1:0];
  assign empty_s    = (head_r == tail_r);
  assign full_s     = (head_idx_s == tail_idx_s) && (head_r[DISP_IDX] != tail_r[DISP_IDX]);
  assign enq_s      = (|rn_valid) && !full_s && !flush;
  assign deq_s      = !empty_s && rs_ready && !flush;
  assign rn_ready   = !full_s;

  // Wakeup matchers: one per stored lane, one per incoming lane, and one per
  // output lane for the head bypass.
  for (genvar s = 0; s < DISP_DEPTH; s++) begin : g_slot
    for (genvar l = 0; l < ID_WIDTH; l++) begin : g_lane
      disp_wakeup #(.CDB_WIDTH(CDB_WIDTH)) u_mem_wake (
        .uop_in     (uop_mem_r[s][l]),
        .cdb_valid  (cdb_valid),
        .cdb_rd_phy (cdb_rd_phy),
        .uop_out    (woken_mem_s[s][l])
      );
    end
  end

  for (genvar l = 0; l < ID_WIDTH; l++) begin : g_io_lane
    disp_wakeup #(.CDB_WIDTH(CDB_WIDTH)) u_rn_wake (
      .uop_in     (rn_uop[l]),
      .cdb_valid  (cdb_valid),
      .cdb_rd_phy (cdb_rd_phy),
      .uop_out    (rn_woken_s[l])
    );
    disp_wakeup #(.CDB_WIDTH(CDB_WIDTH)) u_out_wake (
      .uop_in     (uop_mem_r[head_idx_s][l]),
      .cdb_valid  (cdb_valid),
      .cdb_rd_phy (cdb_rd_phy),
      .uop_out    (rs_uop[l])
    );
  end

  // Present the head group; flush suppresses it so that no transfer counts.
  always_comb begin
    rs_valid = {ID_WIDTH{1'b0}};
    if (!empty_s && !flush) begin
      rs_valid = valid_mem_r[head_idx_s];
    end else begin
      rs_valid = {ID_WIDTH{1'b0}};
    end
  end

  // Pointer update. Flush beats enqueue and dequeue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_r <= {(DISP_IDX+1){1'b0}};
      tail_r <= {(DISP_IDX+1){1'b0}};
    end else if (flush) begin
      head_r <= {(DISP_IDX+1){1'b0}};
      tail_r <= {(DISP_IDX+1){1'b0}};
    end else begin
      if (enq_s) begin
        tail_r <= tail_r + {{DISP_IDX{1'b0}}, 1'b1};
      end
      if (deq_s) begin
        head_r <= head_r + {{DISP_IDX{1'b0}}, 1'b1};
      end
    end
  end

  // Slot storage: apply wakeup to every slot, then write the enqueued group,
  // which has already been woken by this cycle's broadcasts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < DISP_DEPTH; s++) begin
        valid_mem_r[s] <= {ID_WIDTH{1'b0}};
        uop_mem_r[s]   <= '0;
      end
    end else if (!flush) begin
      for (int s = 0; s < DISP_DEPTH; s++) begin
        uop_mem_r[s] <= woken_mem_s[s];
      end
      if (enq_s) begin
        valid_mem_r[tail_idx_s] <= rn_valid;
        uop_mem_r[tail_idx_s]   <= rn_woken_s;
      end
    end
  end

endmodule

// File: tb/tb_int_dispatch_buf.sv
// Directed self-checking bench for int_dispatch_buf.
// Inputs are driven on the falling edge, and outputs are sampled 1 ns later.
module tb_int_dispatch_buf;
  import uop_types::*;

  typedef uop_t [1:0] grp_t;

  logic            clk;
  logic            rst;
  logic            flush;
  logic [1:0]      rn_valid;
  grp_t            rn_uop;
  logic            rn_ready;
  logic [1:0]      rs_valid;
  grp_t            rs_uop;
  logic            rs_ready;
  logic [1:0]      cdb_valid;
  logic [1:0][5:0] cdb_rd_phy;

  int checks = 0;
  int errors = 0;

  int_dispatch_buf dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .rn_valid   (rn_valid),
    .rn_uop     (rn_uop),
    .rn_ready   (rn_ready),
    .rs_valid   (rs_valid),
    .rs_uop     (rs_uop),
    .rs_ready   (rs_ready),
    .cdb_valid  (cdb_valid),
    .cdb_rd_phy (cdb_rd_phy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic uop_t mk(input logic [7:0] op, input logic [5:0] rs1, input logic v1,
                              input logic [5:0] rs2, input logic v2);
    uop_t u;
    u.opcode    = op;
    u.rd_phy    = op[5:0];
    u.rs1_phy   = rs1;
    u.rs1_valid = v1;
    u.rs2_phy   = rs2;
    u.rs2_valid = v2;
    return u;
  endfunction

  function automatic grp_t grp(input int n);
    grp_t g;
    for (int l = 0; l < 2; l++) begin
      g[l] = mk(8'(n * 2 + l), 6'(10 + l), 1'b1, 6'(20 + l), 1'b1);
    end
    return g;
  endfunction

  task automatic test_reset;
    rst = 1'b0; flush = 1'b0; rn_valid = 2'b00; rn_uop = '0; rs_ready = 1'b0;
    cdb_valid = 2'b00; cdb_rd_phy = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (rn_ready !== 1'b1) begin errors++; $display("FAIL reset_rn_ready: got %b want 1", rn_ready); end
    checks++; if (rs_valid !== 2'b00) begin errors++; $display("FAIL reset_rs_valid: got %b want 00", rs_valid); end
  endtask

  task automatic test_basic;
    grp_t g;
    g[0] = mk(8'hA0, 6'd1, 1'b1, 6'd2, 1'b1);
    g[1] = mk(8'hB0, 6'd3, 1'b1, 6'd4, 1'b0);
    @(negedge clk);
    rn_valid = 2'b11; rn_uop = g; rs_ready = 1'b1;
    #1;
    checks++; if (rs_valid !== 2'b00) begin errors++; $display("FAIL basic_empty: got %b want 00", rs_valid); end
    @(negedge clk);
    rn_valid = 2'b00;
    #1;
    checks++; if (rs_valid !== 2'b11) begin errors++; $display("FAIL basic_valid: got %b want 11", rs_valid); end
    checks++; if (rs_uop !== g) begin errors++; $display("FAIL basic_uop: got %h want %h", rs_uop, g); end
    @(negedge clk);
    #1;
    checks++; if (rs_valid !== 2'b00) begin errors++; $display("FAIL basic_drained: got %b want 00", rs_valid); end
    rs_ready = 1'b0;
  endtask

  task automatic test_fill;
    rs_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rn_valid = 2'b11; rn_uop = grp(i);
      #1;
      checks++;
      if (rn_ready !== (i < 4)) begin errors++; $display("FAIL fill_rn_ready[%0d]: got %b want %b", i, rn_ready, (i < 4)); end
    end
    @(negedge clk);
    rs_ready = 1'b1;
    #1;
    checks++; if (rn_ready !== 1'b0) begin errors++; $display("FAIL fill_full_hold: got %b want 0", rn_ready); end
    checks++; if (rs_uop !== grp(0)) begin errors++; $display("FAIL fill_head0: got %h want %h", rs_uop, grp(0)); end
    @(negedge clk);
    rs_ready = 1'b0;
    #1;
    checks++; if (rn_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_rise: got %b want 1", rn_ready); end
    @(negedge clk);
    rn_valid = 2'b00; rs_ready = 1'b1;
    for (int j = 1; j < 5; j++) begin
      if (j > 1) @(negedge clk);
      #1;
      checks++; if (rs_valid !== 2'b11) begin errors++; $display("FAIL fill_drain_valid[%0d]: got %b want 11", j, rs_valid); end
      checks++; if (rs_uop !== grp(j)) begin errors++; $display("FAIL fill_drain_order[%0d]: got %h want %h", j, rs_uop, grp(j)); end
    end
    @(negedge clk);
    #1;
    checks++; if (rs_valid !== 2'b00) begin errors++; $display("FAIL fill_empty: got %b want 00", rs_valid); end
    rs_ready = 1'b0;
  endtask

  task automatic test_stored_wakeup;
    @(negedge clk);
    rn_valid = 2'b01; rn_uop[0] = mk(8'h40, 6'd7, 1'b0, 6'd30, 1'b1); rn_uop[1] = mk(8'h41, 6'd12, 1'b0, 6'd13, 1'b0);
    @(negedge clk);
    rn_valid = 2'b00; cdb_valid = 2'b10; cdb_rd_phy[1] = 6'd7; cdb_rd_phy[0] = 6'd33;
    @(negedge clk);
    cdb_valid = 2'b00; rs_ready = 1'b1;
    #1;
    checks++; if (rs_valid !== 2'b01) begin errors++; $display("FAIL stored_valid: got %b want 01", rs_valid); end
    checks++; if (rs_uop[0].rs1_valid !== 1'b1) begin errors++; $display("FAIL stored_rs1_wake: got %b want 1", rs_uop[0].rs1_valid); end
    @(negedge clk);
    rs_ready = 1'b0;
    rn_valid = 2'b01; rn_uop[0] = mk(8'h42, 6'd5, 1'b0, 6'd31, 1'b0);
    cdb_valid = 2'b01; cdb_rd_phy[0] = 6'd31;
    @(negedge clk);
    rn_valid = 2'b00; cdb_valid = 2'b00; rs_ready = 1'b1;
    #1;
    checks++; if (rs_uop[0].rs2_valid !== 1'b1) begin errors++; $display("FAIL enq_cycle_wake: got %b want 1", rs_uop[0].rs2_valid); end
    checks++; if (rs_uop[0].rs1_valid !== 1'b0) begin errors++; $display("FAIL enq_cycle_nowake: got %b want 0", rs_uop[0].rs1_valid); end
    @(negedge clk);
    rs_ready = 1'b0;
  endtask

  task automatic test_bypass_p0;
    @(negedge clk);
    rn_valid = 2'b01; rn_uop[0] = mk(8'h50, 6'd0, 1'b0, 6'd9, 1'b0);
    @(negedge clk);
    rn_valid = 2'b00; rs_ready = 1'b1; cdb_valid = 2'b01; cdb_rd_phy[0] = 6'd9;
    #1;
    checks++; if (rs_valid !== 2'b01) begin errors++; $display("FAIL bypass_valid: got %b want 01", rs_valid); end
    checks++; if (rs_uop[0].rs2_valid !== 1'b1) begin errors++; $display("FAIL bypass_rs2: got %b want 1", rs_uop[0].rs2_valid); end
    @(negedge clk);
    rs_ready = 1'b0; cdb_valid = 2'b00;
    #1;
    checks++; if (rs_valid !== 2'b00) begin errors++; $display("FAIL bypass_taken: got %b want 00", rs_valid); end
    rn_valid = 2'b01; rn_uop[0] = mk(8'h51, 6'd0, 1'b0, 6'd3, 1'b1);
    cdb_valid = 2'b11; cdb_rd_phy[0] = 6'd0; cdb_rd_phy[1] = 6'd0;
    @(negedge clk);
    rn_valid = 2'b00;
    #1;
    checks++; if (rs_uop[0].rs1_valid !== 1'b0) begin errors++; $display("FAIL p0_bypass: got %b want 0", rs_uop[0].rs1_valid); end
    @(negedge clk);
    cdb_valid = 2'b00; rs_ready = 1'b1;
    #1;
    checks++; if (rs_uop[0].rs1_valid !== 1'b0) begin errors++; $display("FAIL p0_stored: got %b want 0", rs_uop[0].rs1_valid); end
    @(negedge clk);
    rs_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c < 9) begin
        rn_valid = 2'b11; rn_uop = grp(100 + c);
      end else begin
        rn_valid = 2'b00;
      end
      rs_ready = (c >= 2);
      #1;
      if (c < 9) begin
        checks++; if (rn_ready !== 1'b1) begin errors++; $display("FAIL b2b_rn_ready[%0d]: got %b want 1", c, rn_ready); end
      end
      if (c >= 2) begin
        checks++; if (rs_uop !== grp(98 + c)) begin errors++; $display("FAIL b2b_order[%0d]: got %h want %h", c, rs_uop, grp(98 + c)); end
      end
    end
    @(negedge clk);
    rs_ready = 1'b0;
    #1;
    checks++; if (rs_valid !== 2'b00) begin errors++; $display("FAIL b2b_empty: got %b want 00", rs_valid); end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rn_valid = 2'b11; rn_uop = grp(60 + i);
    end
    @(negedge clk);
    flush = 1'b1; rn_uop = grp(70); rs_ready = 1'b1;
    #1;
    checks++; if (rs_valid !== 2'b00) begin errors++; $display("FAIL flush_cycle: got %b want 00", rs_valid); end
    @(negedge clk);
    flush = 1'b0; rn_valid = 2'b00; rs_ready = 1'b0;
    #1;
    checks++; if (rs_valid !== 2'b00) begin errors++; $display("FAIL flush_empty: got %b want 00", rs_valid); end
    checks++; if (rn_ready !== 1'b1) begin errors++; $display("FAIL flush_rn_ready: got %b want 1", rn_ready); end
    rn_valid = 2'b11; rn_uop = grp(71);
    @(negedge clk);
    rn_valid = 2'b00; rs_ready = 1'b1;
    #1;
    checks++; if (rs_uop !== grp(71)) begin errors++; $display("FAIL flush_next: got %h want %h", rs_uop, grp(71)); end
    @(negedge clk);
    #1;
    checks++; if (rs_valid !== 2'b00) begin errors++; $display("FAIL flush_only_one: got %b want 00", rs_valid); end
    rs_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rn_valid = 2'b11; rn_uop = grp(80 + i);
    end
    @(negedge clk);
    rst = 1'b0; rs_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1; rn_valid = 2'b00; rs_ready = 1'b0;
    #1;
    checks++; if (rs_valid !== 2'b00) begin errors++; $display("FAIL rstmid_empty: got %b want 00", rs_valid); end
    checks++; if (rn_ready !== 1'b1) begin errors++; $display("FAIL rstmid_rn_ready: got %b want 1", rn_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_stored_wakeup();
    test_bypass_p0();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
